alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Issue/operand stage directly upstream of the 8-bit combinational ALU (operands a, b; 4-bit select; 32-bit result).
- Accepts 16-bit instructions over a valid/ready handshake and holds an 8×8-bit register file.
- Drives ALU operands from a pipeline register and captures the ALU result into a writeback/result register.
- Writes the result's low byte back to the register file and forwards it to dependent instructions; no stall on data hazards.

Parameters:
- NREGS, 8, register-file depth; fixed at 8 by the 3-bit register fields.
- DW, 8, register and operand width; must match the ALU operand width.
- RW, 32, ALU result width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  stage can accept an instruction this cycle.
- instr  in  16  instruction word; format under Behaviour.
- alu_a  out  DW  ALU operand a (registered).
- alu_b  out  DW  ALU operand b (registered).
- alu_sel  out  4  ALU function select (registered).
- alu_result  in  RW  combinational ALU output for the current alu_a/alu_b/alu_sel.
- res_valid  out  1  result register holds a valid result.
- res_ready  in  1  downstream consumes the result.
- res_data  out  RW  captured full ALU result.
- res_rd  out  3  destination register of res_data.
- res_zero  out  1  res_data == 0, computed in this block.
- dbg_addr  in  3  debug read address.
- dbg_data  out  DW  combinational rf[dbg_addr]; for verification only.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Values during reset: all 8 registers = 0; ex_valid = 0; res_valid = 0; res_data = 0; res_rd = 0; res_zero = 0; alu_a = alu_b = 0; alu_sel = 0.
- Instruction formats:
  - instr[15] = 1 is LI: rd = instr[14:12], imm = instr[7:0]. Issues alu_a = imm, alu_b = 0, alu_sel = 4'b0010 (add).
  - instr[15] = 0 is OP: alu_sel = instr[14:11], rd = instr[10:8], rs1 = instr[7:5], rs2 = instr[4:2]; instr[1:0] are ignored.
- Pipeline: issue (IS) → execute register (EX, drives the ALU) → result register (RS).
- adv = !res_valid || res_ready.
- instr_ready = adv; it is combinational and never depends on instr_valid.
- When adv is high:
  - EX → RS: if ex_valid, res_data ← alu_result, res_rd ← ex_rd, res_zero ← (alu_result == 0), res_valid ← 1, and rf[ex_rd] ← alu_result[DW-1:0] on the same edge.
  - If ex_valid = 0: res_valid ← 0.
  - IS → EX: ex_valid ← instr_valid. On accept, the operands, select and rd are loaded into EX.
- When adv is low: EX and RS hold; nothing is written; no instruction is accepted.
- Operand read for an OP is rf[rsN] with forwarding:
  - If ex_valid and ex_rd == rsN and adv, the operand is alu_result[DW-1:0].
  - Otherwise the operand is the register-file value.
  - Priority: EX forward over register file.
  - Result: back-to-back dependent instructions see the new value; 0 stall cycles.
- Latency: the instruction is accepted at edge N, its result is visible in res_data after edge N+1, and the register file is updated at edge N+1.
- Throughput: 1 instruction per cycle when res_ready is held high.
- rd == rs1 == rs2 is legal; the operands read the old (or forwarded) value.
- The upper result bits (mul, shift) appear only in res_data; the register file keeps the low byte, truncated.
- Division by zero is passed through unmodified; its value is defined by the ALU.
- res_valid high with res_ready low: res_data, res_rd and res_zero are stable until the handshake.
- Reset asserted mid-operation: in-flight EX/RS contents are discarded and the register file is cleared; the first instruction can be accepted at the first edge after release.
- All register 0..7 are general-purpose; there is no hardwired zero register.

Decomposition:
- Shared package alu_pkg: ALU select constants (ALU_AND = 4'b0000 … ALU_EQ = 4'b1111), DW/RW, instruction field positions, LI/OP opcode bit.
- Sub-module regfile_8x8: 8×8 register file with async reset, 1 write port, 2 combinational read ports plus a debug read port.
- Forwarding and handshake logic stay in alu_issue_stage.

Test Plan:
- Reset: assert rst_n = 0 mid-stream → res_valid = 0, instr_ready = 1 after release, dbg_data = 0 for all addresses.
- Back-to-back dependency, res_ready = 1: LI r1,5; LI r2,3; ADD(0010) r3,r1,r2 issued on consecutive cycles → res_data = 8, res_rd = 3, no stall; rf[3] = 8.
- Wide result: LI r1,200; LI r2,200; MUL(1001) r4,r1,r2 → res_data = 40000, rf[4] = 8'h40; SUB(0011) r5,r2,r2 → res_data = 0, res_zero = 1.
- Backpressure: res_ready = 0 for 3 cycles with 3 instructions offered → instr_ready = 0 after RS fills, res_data held stable; on release, results drain in order with no loss or duplication.
- Self-dependency: LI r6,1; ADD r6,r6,r6 ×3 back-to-back → res_data sequence 2, 4, 8; rf[6] = 8.
- Reset mid-operation: reset while EX and RS are both valid → no write to rf[rd]; all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU select codes, widths, instruction field positions and stage structs.
// Pure declarations; no latency or backpressure of its own.
// Imported by the issue stage and its register file.
package alu_pkg;

  localparam int NREGS   = 8;
  localparam int DW      = 8;
  localparam int RW      = 32;
  localparam int AW      = 3;
  localparam int INSTR_W = 16;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_MUL  = 4'b1001;
  localparam logic [3:0] ALU_DIV  = 4'b1010;
  localparam logic [3:0] ALU_MOD  = 4'b1011;
  localparam logic [3:0] ALU_SLT  = 4'b1100;
  localparam logic [3:0] ALU_SLTU = 4'b1101;
  localparam logic [3:0] ALU_NE   = 4'b1110;
  localparam logic [3:0] ALU_EQ   = 4'b1111;

  // Instruction word layout; bit 15 set selects LI, clear selects OP.
  localparam int OPC_BIT   = 15;
  localparam int LI_RD_HI  = 14;
  localparam int LI_RD_LO  = 12;
  localparam int IMM_HI    = 7;
  localparam int IMM_LO    = 0;
  localparam int OP_SEL_HI = 14;
  localparam int OP_SEL_LO = 11;
  localparam int OP_RD_HI  = 10;
  localparam int OP_RD_LO  = 8;
  localparam int RS1_HI    = 7;
  localparam int RS1_LO    = 5;
  localparam int RS2_HI    = 4;
  localparam int RS2_LO    = 2;

  typedef struct packed {
    logic          is_li;
    logic [3:0]    sel;
    logic [AW-1:0] li_rd;
    logic [AW-1:0] op_rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [DW-1:0] imm;
  } dec_t;

  typedef struct packed {
    logic [3:0]    sel;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [AW-1:0] rd;
  } ex_t;

endpackage

// File: rtl/regfile_8x8.sv
// 8x8 register file: one write port, two operand read ports, one debug read port.
// Reads are combinational; the write lands on the rising edge.
// No backpressure; the caller gates the write enable.
module regfile_8x8
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata2,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1   = mem[raddr1];
  assign rdata2   = mem[raddr2];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/operand stage feeding an external combinational ALU, with result register and writeback.
// Latency: accepted at edge N, result in res_data and register file after edge N+1.
// Backpressure: res_ready low with a held result freezes EX/RS and drops instr_ready.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [DW-1:0]      alu_a,
  output logic [DW-1:0]      alu_b,
  output logic [3:0]         alu_sel,
  input  logic [RW-1:0]      alu_result,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [RW-1:0]      res_data,
  output logic [AW-1:0]      res_rd,
  output logic               res_zero,
  input  logic [AW-1:0]      dbg_addr,
  output logic [DW-1:0]      dbg_data
);

  logic          adv;
  logic          ex_valid;
  ex_t           ex_q;
  ex_t           ex_d;
  dec_t          dec;
  logic [DW-1:0] rf_rd1;
  logic [DW-1:0] rf_rd2;
  logic [DW-1:0] opnd_a;
  logic [DW-1:0] opnd_b;
  logic          fwd1;
  logic          fwd2;
  logic          rf_we;
  logic          unused_instr_bits;

  assign adv         = !res_valid || res_ready;
  assign instr_ready = adv;

  always_comb begin
    dec       = '0;
    dec.is_li = instr[OPC_BIT];
    dec.sel   = instr[OP_SEL_HI:OP_SEL_LO];
    dec.li_rd = instr[LI_RD_HI:LI_RD_LO];
    dec.op_rd = instr[OP_RD_HI:OP_RD_LO];
    dec.rs1   = instr[RS1_HI:RS1_LO];
    dec.rs2   = instr[RS2_HI:RS2_LO];
    dec.imm   = instr[IMM_HI:IMM_LO];
  end

  assign unused_instr_bits = ^instr[1:0];

  regfile_8x8 u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (ex_q.rd),
    .wdata    (alu_result[DW-1:0]),
    .raddr1   (dec.rs1),
    .rdata1   (rf_rd1),
    .raddr2   (dec.rs2),
    .rdata2   (rf_rd2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // The EX result is written on the same edge this operand is captured, so the
  // register file still holds the old value; take it straight off the ALU.
  assign fwd1   = ex_valid && adv && (ex_q.rd == dec.rs1);
  assign fwd2   = ex_valid && adv && (ex_q.rd == dec.rs2);
  assign opnd_a = fwd1 ? alu_result[DW-1:0] : rf_rd1;
  assign opnd_b = fwd2 ? alu_result[DW-1:0] : rf_rd2;

  always_comb begin
    ex_d = '0;
    if (dec.is_li) begin
      ex_d.a   = dec.imm;
      ex_d.b   = '0;
      ex_d.sel = ALU_ADD;
      ex_d.rd  = dec.li_rd;
    end else begin
      ex_d.a   = opnd_a;
      ex_d.b   = opnd_b;
      ex_d.sel = dec.sel;
      ex_d.rd  = dec.op_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_q     <= '0;
    end else if (adv) begin
      ex_valid <= instr_valid;
      if (instr_valid) begin
        ex_q <= ex_d;
      end
    end
  end

  assign rf_we = adv && ex_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_rd    <= '0;
      res_zero  <= 1'b0;
    end else if (adv) begin
      res_valid <= ex_valid;
      if (ex_valid) begin
        res_data <= alu_result;
        res_rd   <= ex_q.rd;
        res_zero <= (alu_result == '0);
      end
    end
  end

  assign alu_a   = ex_q.a;
  assign alu_b   = ex_q.b;
  assign alu_sel = ex_q.sel;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU hanging off alu_a/alu_b/alu_sel.
// Inputs driven and outputs sampled on the falling edge.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_valid;
  logic          instr_ready;
  logic [15:0]   instr;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    alu_sel;
  logic [RW-1:0] alu_result;
  logic          res_valid;
  logic          res_ready;
  logic [RW-1:0] res_data;
  logic [2:0]    res_rd;
  logic          res_zero;
  logic [2:0]    dbg_addr;
  logic [DW-1:0] dbg_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_result  (alu_result),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_rd      (res_rd),
    .res_zero    (res_zero),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always_comb begin
    alu_result = '0;
    case (alu_sel)
      ALU_AND: alu_result = {24'h0, alu_a & alu_b};
      ALU_OR:  alu_result = {24'h0, alu_a | alu_b};
      ALU_ADD: alu_result = 32'(alu_a) + 32'(alu_b);
      ALU_SUB: alu_result = 32'(alu_a) - 32'(alu_b);
      ALU_MUL: alu_result = 32'(alu_a) * 32'(alu_b);
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc_li(input logic [2:0] rd, input logic [7:0] imm);
    return {1'b1, rd, 4'b0000, imm};
  endfunction

  function automatic logic [15:0] enc_op(input logic [3:0] sel, input logic [2:0] rd,
                                         input logic [2:0] rs1, input logic [2:0] rs2);
    return {1'b0, sel, rd, rs1, rs2, 2'b11};
  endfunction

  task automatic cyc(input logic v, input logic [15:0] w);
    instr_valid = v;
    instr       = w;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rf_chk(input string tag, input logic [2:0] addr, input logic [7:0] exp);
    dbg_addr = addr;
    #1;
    check(tag, {24'h0, dbg_data}, {24'h0, exp});
  endtask

  task automatic res_chk(input string tag, input logic [31:0] data, input logic [2:0] rd);
    check({tag, "_vld"},  {31'h0, res_valid}, 32'd1);
    check({tag, "_data"}, res_data, data);
    check({tag, "_rd"},   {29'h0, res_rd}, {29'h0, rd});
    check({tag, "_zero"}, {31'h0, res_zero}, {31'h0, (data == 32'h0)});
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    res_ready   = 1'b1;
    dbg_addr    = '0;

    // Reset state
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = enc_li(3'd1, 8'd9);
    @(posedge clk);
    @(negedge clk);
    check("rst_res_vld",  {31'h0, res_valid}, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_alu_a",    {24'h0, alu_a}, 32'd0);
    check("rst_alu_sel",  {28'h0, alu_sel}, 32'd0);
    for (int i = 0; i < 8; i++) rf_chk("rst_rf", 3'(i), 8'd0);
    instr_valid = 1'b0;
    rst_n       = 1'b1;
    #1;
    check("rst_rdy", {31'h0, instr_ready}, 32'd1);

    // Back-to-back dependency with forwarding
    cyc(1'b1, enc_li(3'd1, 8'd5));
    cyc(1'b1, enc_li(3'd2, 8'd3));
    res_chk("dep_li1", 32'd5, 3'd1);
    check("dep_rdy", {31'h0, instr_ready}, 32'd1);
    cyc(1'b1, enc_op(ALU_ADD, 3'd3, 3'd1, 3'd2));
    res_chk("dep_li2", 32'd3, 3'd2);
    cyc(1'b0, '0);
    res_chk("dep_add", 32'd8, 3'd3);
    rf_chk("dep_rf3", 3'd3, 8'd8);
    cyc(1'b0, '0);
    check("dep_drain", {31'h0, res_valid}, 32'd0);

    // Wide result and zero flag
    cyc(1'b1, enc_li(3'd1, 8'd200));
    cyc(1'b1, enc_li(3'd2, 8'd200));
    cyc(1'b1, enc_op(ALU_MUL, 3'd4, 3'd1, 3'd2));
    res_chk("wide_li2", 32'd200, 3'd2);
    cyc(1'b1, enc_op(ALU_SUB, 3'd5, 3'd2, 3'd2));
    res_chk("wide_mul", 32'd40000, 3'd4);
    cyc(1'b0, '0);
    res_chk("wide_sub", 32'd0, 3'd5);
    rf_chk("wide_rf4", 3'd4, 8'h40);
    rf_chk("wide_rf5", 3'd5, 8'h00);
    cyc(1'b0, '0);

    // Backpressure: result register fills, stage stalls, then drains in order
    res_ready = 1'b0;
    cyc(1'b1, enc_li(3'd1, 8'd10));
    check("bp_empty", {31'h0, res_valid}, 32'd0);
    cyc(1'b1, enc_li(3'd2, 8'd20));
    res_chk("bp_hold1", 32'd10, 3'd1);
    check("bp_rdy1", {31'h0, instr_ready}, 32'd0);
    cyc(1'b1, enc_li(3'd3, 8'd30));
    res_chk("bp_hold2", 32'd10, 3'd1);
    check("bp_rdy2", {31'h0, instr_ready}, 32'd0);
    rf_chk("bp_rf2_old", 3'd2, 8'd200);
    res_ready = 1'b1;
    #1;
    check("bp_rdy3", {31'h0, instr_ready}, 32'd1);
    cyc(1'b1, enc_li(3'd3, 8'd30));
    res_chk("bp_out20", 32'd20, 3'd2);
    cyc(1'b0, '0);
    res_chk("bp_out30", 32'd30, 3'd3);
    cyc(1'b0, '0);
    check("bp_nodup", {31'h0, res_valid}, 32'd0);
    rf_chk("bp_rf3", 3'd3, 8'd30);

    // Self-dependency chain
    cyc(1'b1, enc_li(3'd6, 8'd1));
    cyc(1'b1, enc_op(ALU_ADD, 3'd6, 3'd6, 3'd6));
    res_chk("self_li", 32'd1, 3'd6);
    cyc(1'b1, enc_op(ALU_ADD, 3'd6, 3'd6, 3'd6));
    res_chk("self_a1", 32'd2, 3'd6);
    cyc(1'b1, enc_op(ALU_ADD, 3'd6, 3'd6, 3'd6));
    res_chk("self_a2", 32'd4, 3'd6);
    cyc(1'b0, '0);
    res_chk("self_a3", 32'd8, 3'd6);
    rf_chk("self_rf6", 3'd6, 8'd8);
    cyc(1'b0, '0);

    // Reset with EX and RS both occupied
    cyc(1'b1, enc_li(3'd0, 8'd77));
    cyc(1'b1, enc_li(3'd7, 8'd99));
    res_chk("mid_pre", 32'd77, 3'd0);
    rst_n = 1'b0;
    #1;
    check("mid_res_vld",  {31'h0, res_valid}, 32'd0);
    check("mid_res_data", res_data, 32'd0);
    check("mid_alu_a",    {24'h0, alu_a}, 32'd0);
    check("mid_alu_b",    {24'h0, alu_b}, 32'd0);
    check("mid_alu_sel",  {28'h0, alu_sel}, 32'd0);
    rf_chk("mid_rf0", 3'd0, 8'd0);
    cyc(1'b1, enc_li(3'd7, 8'd99));
    rf_chk("mid_rf7", 3'd7, 8'd0);
    check("mid_vld2", {31'h0, res_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("mid_rdy", {31'h0, instr_ready}, 32'd1);
    cyc(1'b1, enc_li(3'd4, 8'd5));
    cyc(1'b0, '0);
    res_chk("mid_first", 32'd5, 3'd4);
    rf_chk("mid_rf4", 3'd4, 8'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
